// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, HI/LO write and result signals of the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, op, a, b, hi_we, lo_we, wdata,
                   input  busy, done, div_by_zero, hi, lo);
   modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                   output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide, one bit per cycle on operand magnitudes.
module muldiv_unit #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1
) (
   input logic           clock,
   input logic           reset,
   muldiv_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
   state_t state_q, state_d;
   logic div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, bz_q, bz_d;
   logic done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic sgn, sa, sb, ge;
   logic [WIDTH-1:0] mag_a, mag_b, sub, rem_new, quo, rem;
   logic [WIDTH:0] add_sum, shl;
   logic [2*WIDTH-1:0] prod;
   assign sgn   = SIGNED_EN && !bus.op[0];
   assign sa    = sgn & bus.a[WIDTH-1];
   assign sb    = sgn & bus.b[WIDTH-1];
   assign mag_a = sa ? -bus.a : bus.a;
   assign mag_b = sb ? -bus.b : bus.b;
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
   assign shl     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign ge      = shl >= {1'b0, m_q};
   assign sub     = shl[WIDTH-1:0] - m_q;
   assign rem_new = ge ? sub : shl[WIDTH-1:0];
   assign prod    = neg_lo_q ? -acc_q : acc_q;
   assign quo     = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem     = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      bz_d     = bz_q;
      m_d      = m_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            hi_d = bus.hi_we ? bus.wdata : hi_q;
            lo_d = bus.lo_we ? bus.wdata : lo_q;
            if (bus.start) begin
               state_d  = CALC;
               div_d    = bus.op[1];
               neg_lo_d = sa ^ sb;
               neg_hi_d = sa;
               bz_d     = bus.b == '0;
               m_d      = bus.op[1] ? mag_b : mag_a;
               acc_d    = {{WIDTH{1'b0}}, bus.op[1] ? mag_a : mag_b};
               cnt_d    = CW'(WIDTH);
            end
         end
         CALC: begin
            acc_d   = div_q ? {rem_new, acc_q[WIDTH-2:0], ge} : {add_sum, acc_q[WIDTH-1:1]};
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? FINISH : CALC;
         end
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
            dbz_d   = div_q & bz_q;
            hi_d    = div_q ? (bz_q ? '0 : rem) : prod[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? (bz_q ? '0 : quo) : prod[WIDTH-1:0];
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         bz_q     <= 1'b0;
         m_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         bz_q     <= bz_d;
         m_q      <= m_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end
   assign bus.busy        = state_q != IDLE;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for the 32-bit multiply/divide unit.
module tb_muldiv_unit;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0, failures = 0, cyc = 0, t0 = 0;
   logic seen;
   muldiv_unit_if #(.WIDTH(32)) bus ();
   muldiv_unit #(.WIDTH(32), .SIGNED_EN(1)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clock); #1;
      t0        = cyc;
      bus.start = 1'b0;
      bus.op    = ~op;
      bus.a     = ~a;
      bus.b     = ~b;
   endtask
   task automatic wait_done(input string tag);
      for (int i = 0; i < 100 && !bus.done; i++) begin
         @(posedge clock); #1;
      end
      check({tag, "_done"}, 64'(bus.done), 64'd1);
   endtask
   task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
      launch(op, a, b);
      wait_done(tag);
      check({tag, "_lat"}, 64'(cyc - t0), 64'd33);
      check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
   endtask
   initial begin
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run("mult_minsq", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      run("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run("divu", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
      run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run("div_rem_neg", DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
      run("divu_zero", DIVU, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1);
      run("divu_after0", DIVU, 32'd6, 32'd3, 32'h0, 32'd2, 1'b0);
      @(posedge clock); #1;
      check("done_pulse", 64'(bus.done), 64'd0);
      check("dbz_clear", 64'(bus.div_by_zero), 64'd0);
      // start and write busy-time interference on a running MULTU
      launch(MULTU, 32'h10, 32'h20);
      repeat (4) begin @(posedge clock); #1; end
      bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd9; bus.b = 32'd3;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.lo_we = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'h1234;
      @(posedge clock); #1;
      bus.lo_we = 1'b0; bus.hi_we = 1'b0;
      check("busy_mid", 64'(bus.busy), 64'd1);
      check("lo_stable", 64'(bus.lo), 64'd2);
      check("hi_stable", 64'(bus.hi), 64'd0);
      wait_done("ignore");
      check("ignore_lat", 64'(cyc - t0), 64'd33);
      check("ignore_lo", 64'(bus.lo), 64'h200);
      check("ignore_hi", 64'(bus.hi), 64'h0);
      bus.lo_we = 1'b1; bus.wdata = 32'h1234;
      @(posedge clock); #1;
      bus.lo_we = 1'b0;
      check("mtlo_lo", 64'(bus.lo), 64'h1234);
      check("mtlo_hi", 64'(bus.hi), 64'h0);
      // write strobe coinciding with start lands now, result overwrites later
      bus.hi_we = 1'b1; bus.wdata = 32'hAAAA;
      launch(MULTU, 32'd2, 32'd3);
      bus.hi_we = 1'b0;
      check("mthi_start", 64'(bus.hi), 64'hAAAA);
      wait_done("both");
      check("both_hi", 64'(bus.hi), 64'h0);
      check("both_lo", 64'(bus.lo), 64'd6);
      launch(DIV, 32'hFFFF_FF9C, 32'd3);
      repeat (9) begin @(posedge clock); #1; end
      reset = 1'b1;
      #2;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_hi", 64'(bus.hi), 64'd0);
      check("arst_lo", 64'(bus.lo), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         seen |= bus.done;
      end
      check("arst_nodone", 64'(seen), 64'd0);
      run("post_rst", MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
